// File: rtl/exec_stage_fwd_pipe_if.sv
// Decode-to-execute-to-MEM bundle for exec_stage_fwd_pipe: instruction, forwarding
// network and result-side handshake. The slave view is the execute stage itself.
interface exec_stage_fwd_pipe_if #(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_FWD    = 2
);
  logic                          valid_i;
  logic                          ready_o;
  logic [2:0]                    op_i;
  logic                          update_flag_i;
  logic                          imm_sel_i;
  logic [ADDR_WIDTH-1:0]         reg_addr_1_i;
  logic [ADDR_WIDTH-1:0]         reg_addr_2_i;
  logic [WORD-1:0]               reg_data_1_i;
  logic [WORD-1:0]               reg_data_2_i;
  logic [WORD-1:0]               immediate_i;
  logic [ADDR_WIDTH-1:0]         reg_dest_i;
  logic [NUM_FWD-1:0]            fwd_valid_i;
  logic [NUM_FWD*ADDR_WIDTH-1:0] fwd_addr_i;
  logic [NUM_FWD*WORD-1:0]       fwd_data_i;
  logic                          valid_o;
  logic                          ready_i;
  logic [WORD-1:0]               result_o;
  logic [WORD-1:0]               store_data_o;
  logic [ADDR_WIDTH-1:0]         reg_dest_o;
  logic                          reg_write_o;
  logic [3:0]                    status_o;

  modport slave (
    input  valid_i, op_i, update_flag_i, imm_sel_i, reg_addr_1_i, reg_addr_2_i,
           reg_data_1_i, reg_data_2_i, immediate_i, reg_dest_i,
           fwd_valid_i, fwd_addr_i, fwd_data_i, ready_i,
    output ready_o, valid_o, result_o, store_data_o, reg_dest_o, reg_write_o, status_o
  );

  modport master (
    output valid_i, op_i, update_flag_i, imm_sel_i, reg_addr_1_i, reg_addr_2_i,
           reg_data_1_i, reg_data_2_i, immediate_i, reg_dest_i,
           fwd_valid_i, fwd_addr_i, fwd_data_i, ready_i,
    input  ready_o, valid_o, result_o, store_data_o, reg_dest_o, reg_write_o, status_o
  );
endinterface

// File: rtl/exec_stage_fwd_pipe.sv
// Registered execute stage: priority operand forwarding, single-cycle ALU,
// multi-cycle multiplier (IDLE/BUSY/DONE) and NZCV status register.
module exec_stage_fwd_pipe #(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_FWD    = 2,
  parameter int MUL_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  exec_stage_fwd_pipe_if.slave   bus
);
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_ORR = 3'd3;
  localparam logic [2:0] OP_EOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_r, state_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;

  logic [WORD-1:0]      opa_s, reg2_s, opb_s;
  logic [WORD:0]        add_s, sub_s;
  logic [WORD-1:0]      alu_res_s;
  logic                 alu_c_s, alu_v_s, alu_cv_s;

  logic                 ready_s, accept_s, out_free_s, ld_alu_s, ld_mul_s, ld_en_s;
  logic [WORD-1:0]      ld_res_s, ld_store_s;
  logic [ADDR_WIDTH-1:0] ld_dest_s;
  logic                 ld_wr_s, ld_upd_s, ld_cv_s, ld_c_s, ld_v_s;

  logic [WORD-1:0]      mul_a_r, mul_b_r, mul_store_r, prod_s;
  logic [ADDR_WIDTH-1:0] mul_dest_r;
  logic                 mul_upd_r;

  logic                 valid_r, reg_write_r;
  logic [WORD-1:0]      result_r, store_data_r;
  logic [ADDR_WIDTH-1:0] reg_dest_r;
  logic [3:0]           status_r;

  // Operand selection: walk oldest to youngest so the lowest matching slot wins.
  always_comb begin
    opa_s  = bus.reg_data_1_i;
    reg2_s = bus.reg_data_2_i;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      opa_s  = (bus.fwd_valid_i[k] &&
                (bus.fwd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == bus.reg_addr_1_i))
               ? bus.fwd_data_i[k*WORD +: WORD] : opa_s;
      reg2_s = (bus.fwd_valid_i[k] &&
                (bus.fwd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == bus.reg_addr_2_i))
               ? bus.fwd_data_i[k*WORD +: WORD] : reg2_s;
    end
    opb_s = bus.imm_sel_i ? bus.immediate_i : reg2_s;
  end

  assign add_s  = {1'b0, opa_s} + {1'b0, opb_s};
  assign sub_s  = {1'b0, opa_s} + {1'b0, ~opb_s} + {{WORD{1'b0}}, 1'b1};
  assign prod_s = mul_a_r * mul_b_r;

  // Single-cycle ALU; alu_cv_s marks ops that own the C and V flags.
  always_comb begin
    alu_res_s = {WORD{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_cv_s  = 1'b0;
    case (bus.op_i)
      OP_ADD: begin
        alu_res_s = add_s[WORD-1:0];
        alu_c_s   = add_s[WORD];
        alu_v_s   = (opa_s[WORD-1] == opb_s[WORD-1]) && (add_s[WORD-1] != opa_s[WORD-1]);
        alu_cv_s  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res_s = sub_s[WORD-1:0];
        alu_c_s   = sub_s[WORD];
        alu_v_s   = (opa_s[WORD-1] != opb_s[WORD-1]) && (sub_s[WORD-1] != opa_s[WORD-1]);
        alu_cv_s  = 1'b1;
      end
      OP_AND:  alu_res_s = opa_s & opb_s;
      OP_ORR:  alu_res_s = opa_s | opb_s;
      OP_EOR:  alu_res_s = opa_s ^ opb_s;
      OP_MOV:  alu_res_s = opb_s;
      default: alu_res_s = {WORD{1'b0}};
    endcase
  end

  assign out_free_s = !valid_r || bus.ready_i;
  assign ready_s    = (state_r == ST_IDLE) && out_free_s;
  assign accept_s   = bus.valid_i && ready_s;
  assign ld_alu_s   = accept_s && (bus.op_i != OP_MUL);
  assign ld_mul_s   = (state_r == ST_DONE) && out_free_s;
  assign ld_en_s    = ld_alu_s || ld_mul_s;

  // Next-state logic for the multiply sequencer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (bus.op_i == OP_MUL)) begin
          state_nxt_s = ST_BUSY;
          cnt_nxt_s   = CNT_W'(MUL_CYCLES - 1);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1'b1);
        end
      end
      ST_DONE: begin
        if (out_free_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Sequencer state and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Multiply operands and side info captured at accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mul_a_r     <= {WORD{1'b0}};
      mul_b_r     <= {WORD{1'b0}};
      mul_store_r <= {WORD{1'b0}};
      mul_dest_r  <= {ADDR_WIDTH{1'b0}};
      mul_upd_r   <= 1'b0;
    end else if (accept_s && (bus.op_i == OP_MUL)) begin
      mul_a_r     <= opa_s;
      mul_b_r     <= opb_s;
      mul_store_r <= reg2_s;
      mul_dest_r  <= bus.reg_dest_i;
      mul_upd_r   <= bus.update_flag_i;
    end
  end

  // Load source mux: completed multiply or the instruction accepted this cycle.
  always_comb begin
    ld_res_s   = alu_res_s;
    ld_store_s = reg2_s;
    ld_dest_s  = bus.reg_dest_i;
    ld_wr_s    = (bus.op_i != OP_CMP);
    ld_upd_s   = bus.update_flag_i;
    ld_cv_s    = alu_cv_s;
    ld_c_s     = alu_c_s;
    ld_v_s     = alu_v_s;
    if (ld_mul_s) begin
      ld_res_s   = prod_s;
      ld_store_s = mul_store_r;
      ld_dest_s  = mul_dest_r;
      ld_wr_s    = 1'b1;
      ld_upd_s   = mul_upd_r;
      ld_cv_s    = 1'b0;
      ld_c_s     = 1'b0;
      ld_v_s     = 1'b0;
    end else begin
      ld_cv_s = alu_cv_s;
    end
  end

  // Output register: a load wins over retirement, so a same-edge swap keeps valid high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_r      <= 1'b0;
      result_r     <= {WORD{1'b0}};
      store_data_r <= {WORD{1'b0}};
      reg_dest_r   <= {ADDR_WIDTH{1'b0}};
      reg_write_r  <= 1'b0;
    end else if (ld_en_s) begin
      valid_r      <= 1'b1;
      result_r     <= ld_res_s;
      store_data_r <= ld_store_s;
      reg_dest_r   <= ld_dest_s;
      reg_write_r  <= ld_wr_s;
    end else if (valid_r && bus.ready_i) begin
      valid_r      <= 1'b0;
    end
  end

  // NZCV register, written alongside the output register load.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      status_r <= 4'b0000;
    end else if (ld_en_s && ld_upd_s) begin
      status_r[3] <= ld_res_s[WORD-1];
      status_r[2] <= (ld_res_s == {WORD{1'b0}});
      if (ld_cv_s) begin
        status_r[1:0] <= {ld_c_s, ld_v_s};
      end
    end
  end

  assign bus.ready_o      = ready_s;
  assign bus.valid_o      = valid_r;
  assign bus.result_o     = result_r;
  assign bus.store_data_o = store_data_r;
  assign bus.reg_dest_o   = reg_dest_r;
  assign bus.reg_write_o  = reg_write_r;
  assign bus.status_o     = status_r;
endmodule

// File: tb/tb_exec_stage_fwd_pipe.sv
// Directed bench for exec_stage_fwd_pipe: inputs change and outputs are sampled
// on the falling edge, away from the rising edge the design uses.
module tb_exec_stage_fwd_pipe;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  exec_stage_fwd_pipe_if #(.WORD(32), .ADDR_WIDTH(4), .NUM_FWD(2)) bus ();

  exec_stage_fwd_pipe #(.WORD(32), .ADDR_WIDTH(4), .NUM_FWD(2), .MUL_CYCLES(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] op, input logic upd, input logic imm,
                       input logic [3:0] a1, input logic [3:0] a2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] immv, input logic [3:0] dest);
    bus.valid_i       = 1'b1;
    bus.op_i          = op;
    bus.update_flag_i = upd;
    bus.imm_sel_i     = imm;
    bus.reg_addr_1_i  = a1;
    bus.reg_addr_2_i  = a2;
    bus.reg_data_1_i  = d1;
    bus.reg_data_2_i  = d2;
    bus.immediate_i   = immv;
    bus.reg_dest_i    = dest;
    bus.fwd_valid_i   = 2'b00;
  endtask

  task automatic set_idle();
    bus.valid_i     = 1'b0;
    bus.fwd_valid_i = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ready_i = 1'b1;
    drive(3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    set_idle();
    bus.fwd_addr_i = 8'h00;
    bus.fwd_data_i = 64'h0;
    repeat (2) @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", bus.valid_o); end
    checks++; if (bus.result_o !== 32'h0) begin failures++; $display("FAIL rst_result got=%0h exp=0", bus.result_o); end
    checks++; if (bus.status_o !== 4'b0000) begin failures++; $display("FAIL rst_status got=%0b exp=0000", bus.status_o); end
    checks++; if (bus.reg_write_o !== 1'b0) begin failures++; $display("FAIL rst_regwrite got=%0h exp=0", bus.reg_write_o); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h exp=1", bus.ready_o); end
  endtask

  task automatic test_add_sub();
    @(negedge clk);
    drive(3'd0, 1'b1, 1'b0, 4'd1, 4'd2, 32'd5, 32'd7, 32'd0, 4'd9);
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL add_valid got=%0h exp=1", bus.valid_o); end
    checks++; if (bus.result_o !== 32'd12) begin failures++; $display("FAIL add_result got=%0h exp=c", bus.result_o); end
    checks++; if (bus.status_o !== 4'b0000) begin failures++; $display("FAIL add_nzcv got=%0b exp=0000", bus.status_o); end
    checks++; if (bus.reg_dest_o !== 4'd9) begin failures++; $display("FAIL add_dest got=%0h exp=9", bus.reg_dest_o); end
    checks++; if (bus.reg_write_o !== 1'b1) begin failures++; $display("FAIL add_regwrite got=%0h exp=1", bus.reg_write_o); end
    drive(3'd1, 1'b1, 1'b0, 4'd1, 4'd2, 32'd5, 32'd7, 32'd0, 4'd9);
    @(negedge clk);
    checks++; if (bus.result_o !== 32'hFFFFFFFE) begin failures++; $display("FAIL sub_result got=%0h exp=fffffffe", bus.result_o); end
    checks++; if (bus.status_o !== 4'b1000) begin failures++; $display("FAIL sub_nzcv got=%0b exp=1000", bus.status_o); end
    set_idle();
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    drive(3'd0, 1'b0, 1'b0, 4'd3, 4'd3, 32'd1, 32'd2, 32'd0, 4'd3);
    bus.fwd_valid_i = 2'b11;
    bus.fwd_addr_i  = {4'd3, 4'd3};
    bus.fwd_data_i  = {32'h000000BB, 32'h000000AA};
    @(negedge clk);
    checks++; if (bus.result_o !== 32'h154) begin failures++; $display("FAIL fwd_slot0_result got=%0h exp=154", bus.result_o); end
    checks++; if (bus.store_data_o !== 32'hAA) begin failures++; $display("FAIL fwd_slot0_store got=%0h exp=aa", bus.store_data_o); end
    bus.fwd_valid_i = 2'b10;
    @(negedge clk);
    checks++; if (bus.result_o !== 32'h176) begin failures++; $display("FAIL fwd_slot1_result got=%0h exp=176", bus.result_o); end
    checks++; if (bus.store_data_o !== 32'hBB) begin failures++; $display("FAIL fwd_slot1_store got=%0h exp=bb", bus.store_data_o); end
    bus.fwd_valid_i = 2'b11;
    bus.imm_sel_i   = 1'b1;
    bus.immediate_i = 32'h10;
    @(negedge clk);
    checks++; if (bus.result_o !== 32'hBA) begin failures++; $display("FAIL fwd_imm_result got=%0h exp=ba", bus.result_o); end
    checks++; if (bus.store_data_o !== 32'hAA) begin failures++; $display("FAIL fwd_imm_store got=%0h exp=aa", bus.store_data_o); end
    bus.imm_sel_i    = 1'b0;
    bus.reg_addr_1_i = 4'd5;
    bus.fwd_addr_i   = {4'd3, 4'd5};
    @(negedge clk);
    checks++; if (bus.result_o !== 32'h165) begin failures++; $display("FAIL fwd_split_result got=%0h exp=165", bus.result_o); end
    bus.fwd_valid_i = 2'b00;
    @(negedge clk);
    checks++; if (bus.result_o !== 32'h3) begin failures++; $display("FAIL fwd_none_result got=%0h exp=3", bus.result_o); end
    set_idle();
  endtask

  task automatic test_flags();
    @(negedge clk);
    drive(3'd0, 1'b1, 1'b0, 4'd1, 4'd2, 32'h7FFFFFFF, 32'h1, 32'd0, 4'd1);
    @(negedge clk);
    checks++; if (bus.result_o !== 32'h80000000) begin failures++; $display("FAIL ovf_result got=%0h exp=80000000", bus.result_o); end
    checks++; if (bus.status_o !== 4'b1001) begin failures++; $display("FAIL ovf_nzcv got=%0b exp=1001", bus.status_o); end
    drive(3'd7, 1'b1, 1'b0, 4'd1, 4'd2, 32'd3, 32'd3, 32'd0, 4'd4);
    @(negedge clk);
    checks++; if (bus.status_o !== 4'b0110) begin failures++; $display("FAIL cmp_nzcv got=%0b exp=0110", bus.status_o); end
    checks++; if (bus.reg_write_o !== 1'b0) begin failures++; $display("FAIL cmp_regwrite got=%0h exp=0", bus.reg_write_o); end
    drive(3'd7, 1'b0, 1'b0, 4'd1, 4'd2, 32'd1, 32'd2, 32'd0, 4'd4);
    @(negedge clk);
    checks++; if (bus.status_o !== 4'b0110) begin failures++; $display("FAIL cmp_noupd_nzcv got=%0b exp=0110", bus.status_o); end
    drive(3'd4, 1'b1, 1'b0, 4'd1, 4'd2, 32'h80000000, 32'h0, 32'd0, 4'd5);
    @(negedge clk);
    checks++; if (bus.status_o !== 4'b1010) begin failures++; $display("FAIL eor_nzcv got=%0b exp=1010", bus.status_o); end
    checks++; if (bus.reg_write_o !== 1'b1) begin failures++; $display("FAIL eor_regwrite got=%0h exp=1", bus.reg_write_o); end
    set_idle();
  endtask

  task automatic test_mul();
    @(negedge clk);
    drive(3'd6, 1'b1, 1'b0, 4'd1, 4'd2, 32'd6, 32'd7, 32'd0, 4'd2);
    @(negedge clk);
    set_idle();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL mul_busy_ready cyc=%0d got=%0h exp=0", i, bus.ready_o); end
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL mul_busy_valid cyc=%0d got=%0h exp=0", i, bus.valid_o); end
    end
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL mul_done_valid got=%0h exp=0", bus.valid_o); end
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL mul_valid got=%0h exp=1", bus.valid_o); end
    checks++; if (bus.result_o !== 32'd42) begin failures++; $display("FAIL mul_result got=%0h exp=2a", bus.result_o); end
    checks++; if (bus.status_o !== 4'b0010) begin failures++; $display("FAIL mul_nzcv got=%0b exp=0010", bus.status_o); end
    checks++; if (bus.reg_dest_o !== 4'd2) begin failures++; $display("FAIL mul_dest got=%0h exp=2", bus.reg_dest_o); end
    checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL mul_ready_after got=%0h exp=1", bus.ready_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(3'd0, 1'b0, 1'b0, 4'd1, 4'd2, 32'd10, 32'd1, 32'd0, 4'd1);
    @(negedge clk);
    checks++; if (bus.result_o !== 32'd11) begin failures++; $display("FAIL b2b_first got=%0h exp=b", bus.result_o); end
    drive(3'd0, 1'b0, 1'b0, 4'd1, 4'd2, 32'd20, 32'd2, 32'd0, 4'd2);
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL hold_ready cyc=%0d got=%0h exp=0", i, bus.ready_o); end
      checks++; if (bus.result_o !== 32'd11) begin failures++; $display("FAIL hold_result cyc=%0d got=%0h exp=b", i, bus.result_o); end
      checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%0h exp=1", i, bus.valid_o); end
      checks++; if (bus.store_data_o !== 32'd1) begin failures++; $display("FAIL hold_store cyc=%0d got=%0h exp=1", i, bus.store_data_o); end
    end
    bus.ready_i = 1'b1;
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL release_ready got=%0h exp=1", bus.ready_o); end
    @(negedge clk);
    checks++; if (bus.result_o !== 32'd22) begin failures++; $display("FAIL swap_result got=%0h exp=16", bus.result_o); end
    checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL swap_valid got=%0h exp=1", bus.valid_o); end
    checks++; if (bus.reg_dest_o !== 4'd2) begin failures++; $display("FAIL swap_dest got=%0h exp=2", bus.reg_dest_o); end
    set_idle();
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL retire_valid got=%0h exp=0", bus.valid_o); end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    drive(3'd1, 1'b1, 1'b0, 4'd1, 4'd2, 32'd5, 32'd7, 32'd0, 4'd6);
    @(negedge clk);
    drive(3'd6, 1'b1, 1'b0, 4'd1, 4'd2, 32'd3, 32'd4, 32'd0, 4'd7);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    checks++; if (bus.status_o !== 4'b1000) begin failures++; $display("FAIL pre_rst_nzcv got=%0b exp=1000", bus.status_o); end
    checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL pre_rst_busy got=%0h exp=0", bus.ready_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0h exp=0", bus.valid_o); end
    checks++; if (bus.status_o !== 4'b0000) begin failures++; $display("FAIL midrst_nzcv got=%0b exp=0000", bus.status_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%0h exp=1", bus.ready_o); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL midrst_no_result cyc=%0d got=%0h exp=0", i, bus.valid_o); end
      checks++; if (bus.status_o !== 4'b0000) begin failures++; $display("FAIL midrst_no_flags cyc=%0d got=%0b exp=0000", i, bus.status_o); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add_sub();
    test_forwarding();
    test_flags();
    test_mul();
    test_back_to_back();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
